// File: rtl/clk_cycle_counter_if.sv
// Control and status bundle for the clock-cycle counter.
// The master drives the controls and the slave (the counter) returns status.
interface clk_cycle_counter_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cmp_val;
  logic [WIDTH-1:0] count;
  logic             match;
  logic             ovf;
  logic             ovf_sticky;

  modport master (
    output en, clr, load, load_val, cmp_val,
    input  count, match, ovf, ovf_sticky
  );

  modport slave (
    input  en, clr, load, load_val, cmp_val,
    output count, match, ovf, ovf_sticky
  );
endinterface

// File: rtl/clk_cycle_counter.sv
// Enable-gated clock-cycle counter with a compare-match pulse, a wrap pulse,
// a sticky overflow flag and a synchronous load.
// Every output is a flop, so there is no path from an input to an output.
module clk_cycle_counter #(
  parameter int             WIDTH = 32,
  parameter logic [WIDTH-1:0] STEP  = 1
) (
  input logic              clk,
  input logic              rst,
  clk_cycle_counter_if.slave bus
);

  // The extra top bit is the carry out, and it marks a wrap.
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nxt;

  assign sum = {1'b0, bus.count} + {1'b0, STEP};
  assign nxt = sum[WIDTH-1:0];

  // Priority rst > clr > load > en. Match and ovf only fire on a newly produced count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.count      <= '0;
      bus.match      <= 1'b0;
      bus.ovf        <= 1'b0;
      bus.ovf_sticky <= 1'b0;
    end else if (bus.clr) begin
      bus.count      <= '0;
      bus.match      <= 1'b0;
      bus.ovf        <= 1'b0;
      bus.ovf_sticky <= 1'b0;
    end else if (bus.load) begin
      // A load never wraps, even if an increment would have wrapped this cycle.
      bus.count <= bus.load_val;
      bus.match <= (bus.load_val == bus.cmp_val);
      bus.ovf   <= 1'b0;
    end else if (bus.en) begin
      bus.count <= nxt;
      bus.match <= (nxt == bus.cmp_val);
      bus.ovf   <= sum[WIDTH];
      if (sum[WIDTH]) bus.ovf_sticky <= 1'b1;
    end else begin
      // While holding, the count is not new, so neither pulse may fire.
      bus.match <= 1'b0;
      bus.ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clk_cycle_counter.sv
// Bench for clk_cycle_counter. A directed vector table is followed by randomized
// traffic that is checked against an arithmetic reference model.
module tb_clk_cycle_counter;
  localparam int W = 32;
  localparam logic [W-1:0] STEP = 1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  clk_cycle_counter_if #(.WIDTH(W)) bus ();

  clk_cycle_counter #(.WIDTH(W), .STEP(STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string        name;
    logic         rst, en, clr, load;
    logic [W-1:0] load_val, cmp_val;
    logic [W-1:0] e_count;
    logic         e_match, e_ovf, e_sticky;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string name, logic r, logic e, logic c, logic l,
                              logic [W-1:0] lv, logic [W-1:0] cv, logic [W-1:0] ec,
                              logic em, logic eo, logic es);
    vec_t v;
    v.name = name; v.rst = r; v.en = e; v.clr = c; v.load = l;
    v.load_val = lv; v.cmp_val = cv;
    v.e_count = ec; v.e_match = em; v.e_ovf = eo; v.e_sticky = es;
    vecs.push_back(v);
  endfunction

  task automatic drive(logic r, logic e, logic c, logic l, logic [W-1:0] lv, logic [W-1:0] cv);
    rst = r; bus.en = e; bus.clr = c; bus.load = l; bus.load_val = lv; bus.cmp_val = cv;
  endtask

  task automatic check(string name, int idx, logic [W-1:0] ec, logic em, logic eo, logic es);
    checks++;
    if ({bus.count, bus.match, bus.ovf, bus.ovf_sticky} !== {ec, em, eo, es}) begin
      errors++;
      $display("FAIL %s[%0d]: got count=%h match=%b ovf=%b sticky=%b, want count=%h match=%b ovf=%b sticky=%b",
               name, idx, bus.count, bus.match, bus.ovf, bus.ovf_sticky, ec, em, eo, es);
    end
  endtask

  // Reference model state, advanced from the rules with plain arithmetic.
  logic [W-1:0] m_count;
  logic         m_match, m_ovf, m_sticky;

  function automatic void model_step(logic r, logic e, logic c, logic l,
                                     logic [W-1:0] lv, logic [W-1:0] cv);
    longint unsigned total;
    if (!r || c) begin
      m_count = '0; m_match = 0; m_ovf = 0; m_sticky = 0;
    end else if (l) begin
      m_count = lv; m_match = (lv == cv); m_ovf = 0;
    end else if (e) begin
      total   = longint'(m_count) + longint'(STEP);
      m_ovf   = (total >= (64'd1 << W));
      m_count = W'(total % (64'd1 << W));
      m_match = (m_count == cv);
      if (m_ovf) m_sticky = 1;
    end else begin
      m_match = 0; m_ovf = 0;
    end
  endfunction

  initial begin
    logic [W-1:0] cv;
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 32'd1000);

    // 1: reset held with en high
    for (int i = 0; i < 10; i++) add("t1_rst", 0, 1, 0, 0, 0, 1000, 0, 0, 0, 0);
    // 2: hold at zero, then count up one per cycle
    for (int i = 0; i < 2; i++)  add("t2_hold", 1, 0, 0, 0, 0, 1000, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) add("t2_cnt", 1, 1, 0, 0, 0, 1000, i, 0, 0, 0);
    // 3: load near the top, count through the wrap
    add("t3_load", 1, 0, 0, 1, 32'hFFFF_FFFE, 1000, 32'hFFFF_FFFE, 0, 0, 0);
    add("t3_top",  1, 1, 0, 0, 0, 1000, 32'hFFFF_FFFF, 0, 0, 0);
    add("t3_wrap", 1, 1, 0, 0, 0, 1000, 32'h0, 0, 1, 1);
    add("t3_post", 1, 1, 0, 0, 0, 1000, 32'h1, 0, 0, 1);
    add("t3_hold", 1, 0, 0, 0, 0, 1000, 32'h1, 0, 0, 1);
    // 4: compare match at 5, then hold at 5
    add("t4_clr", 1, 0, 1, 0, 0, 5, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) add("t4_cnt", 1, 1, 0, 0, 0, 5, i, (i == 5), 0, 0);
    add("t4_hold", 1, 0, 0, 0, 0, 5, 5, 0, 0, 0);
    add("t4_hold", 1, 0, 0, 0, 0, 5, 5, 0, 0, 0);
    // 5: set sticky, then clr+load together at 7, then load-only
    add("t5_ld",   1, 0, 0, 1, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFF, 0, 0, 0);
    add("t5_wrap", 1, 1, 0, 0, 0, 5, 0, 0, 1, 1);
    add("t5_ld6",  1, 0, 0, 1, 6, 5, 6, 0, 0, 1);
    add("t5_cnt7", 1, 1, 0, 0, 0, 5, 7, 0, 0, 1);
    add("t5_clrld", 1, 1, 1, 1, 100, 5, 0, 0, 0, 0);
    add("t5_ld100", 1, 0, 0, 1, 100, 5, 100, 0, 0, 0);
    // load against a pending wrap gives no ovf; load onto cmp_val matches
    add("ld_top",  1, 0, 0, 1, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFF, 0, 0, 0);
    add("ld_wrap", 1, 1, 0, 1, 3, 5, 3, 0, 0, 0);
    add("ld_match", 1, 0, 0, 1, 5, 5, 5, 1, 0, 0);
    add("ld_hold", 1, 0, 0, 0, 0, 5, 5, 0, 0, 0);
    // 6: reset mid-count at 50, resume counting
    add("t6_ld",  1, 0, 0, 1, 48, 1000, 48, 0, 0, 0);
    add("t6_cnt", 1, 1, 0, 0, 0, 1000, 49, 0, 0, 0);
    add("t6_cnt", 1, 1, 0, 0, 0, 1000, 50, 0, 0, 0);
    add("t6_rst", 0, 1, 0, 0, 0, 1000, 0, 0, 0, 0);
    add("t6_res", 1, 1, 0, 0, 0, 1000, 1, 0, 0, 0);
    add("t6_res", 1, 1, 0, 0, 0, 1000, 2, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].load, vecs[i].load_val, vecs[i].cmp_val);
      @(posedge clk); #1;
      check(vecs[i].name, i, vecs[i].e_count, vecs[i].e_match, vecs[i].e_ovf, vecs[i].e_sticky);
    end

    // Randomized phase: model picks up from the known state reached above.
    m_count = 2; m_match = 0; m_ovf = 0; m_sticky = 0;
    for (int i = 0; i < 3000; i++) begin
      logic r, e, c, l;
      logic [W-1:0] lv;
      r = ($urandom_range(0, 63) != 0);
      c = ($urandom_range(0, 31) == 0);
      l = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 3) != 0);
      lv = ($urandom_range(0, 1) != 0) ? (32'hFFFF_FFFF - W'($urandom_range(0, 6))) : $urandom;
      cv = ($urandom_range(0, 1) != 0) ? (m_count + W'($urandom_range(0, 3))) : $urandom;
      drive(r, e, c, l, lv, cv);
      model_step(r, e, c, l, lv, cv);
      @(posedge clk); #1;
      check("rand", i, m_count, m_match, m_ovf, m_sticky);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
